// File: rtl/wb_arb_pkg.sv
// Shared widths, constants and the FIFO entry type for the writeback-port arbiter.
package wb_arb_pkg;

  localparam int unsigned REG_ADR_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam logic [REG_ADR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADR_W-1:0] rd_adr;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / long-latency unit and the register-file write port.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN
);
  logic                 pipe_wb_ctrl_RegWrite;
  logic [REG_ADR_W-1:0] pipe_rd_adr;
  logic [DATA_W-1:0]    pipe_reg_file_wr_data;
  logic                 lu_valid_i;
  logic [REG_ADR_W-1:0] lu_rd_adr_i;
  logic [DATA_W-1:0]    lu_data_i;
  logic                 lu_ready_o;
  logic                 rf_wr_en_o;
  logic [REG_ADR_W-1:0] rf_wr_adr_o;
  logic [DATA_W-1:0]    rf_wr_data_o;
  logic                 stall_o;
  logic [31:0]          pending_mask_o;

  // Driven by the pipeline / long-latency unit side.
  modport master (
    output pipe_wb_ctrl_RegWrite, pipe_rd_adr, pipe_reg_file_wr_data,
    output lu_valid_i, lu_rd_adr_i, lu_data_i,
    input  lu_ready_o, rf_wr_en_o, rf_wr_adr_o, rf_wr_data_o, stall_o, pending_mask_o
  );

  // Used by the arbiter itself.
  modport slave (
    input  pipe_wb_ctrl_RegWrite, pipe_rd_adr, pipe_reg_file_wr_data,
    input  lu_valid_i, lu_rd_adr_i, lu_data_i,
    output lu_ready_o, rf_wr_en_o, rf_wr_adr_o, rf_wr_data_o, stall_o, pending_mask_o
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Small FIFO of buffered long-latency results; also reports which registers are still pending.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  wb_entry_t   entry_i,
  output logic        full_o,
  output logic        empty_o,
  output wb_entry_t   head_o,
  output logic [31:0] pending_mask_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pending_mask_o = '0;
    offset         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PtrW'(i) - rd_ptr_q;
      if (CntW'(offset) < count_q) pending_mask_o[mem_q[i].rd_adr] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and buffered long-latency results.
// Optional same-cycle bypass of an idle write slot: define WB_PORT_ARBITER_BYPASS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = 32
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic             pipe_req, fifo_req, full, empty, push, pop, bypass;
  logic             stall_q, stall_d;
  logic [WaitW-1:0] wait_q, wait_d;
  wb_entry_t        head, lu_entry;

  assign pipe_req       = bus.pipe_wb_ctrl_RegWrite && (bus.pipe_rd_adr != REG_X0);
  assign fifo_req       = !empty;
  assign bus.lu_ready_o = !full && !rst;
  assign bus.stall_o    = stall_q;
  assign lu_entry       = '{rd_adr: bus.lu_rd_adr_i, data: XLEN'(bus.lu_data_i)};

`ifdef WB_PORT_ARBITER_BYPASS_EN
  assign bypass = empty && !pipe_req && !stall_q && !rst && bus.lu_valid_i &&
                  (bus.lu_rd_adr_i != REG_X0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are dropped.
  assign push = bus.lu_valid_i && bus.lu_ready_o && (bus.lu_rd_adr_i != REG_X0) && !bypass;

  wb_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .pop_i          (pop),
    .entry_i        (lu_entry),
    .full_o         (full),
    .empty_o        (empty),
    .head_o         (head),
    .pending_mask_o (bus.pending_mask_o)
  );

  // While stalled the MEM/WB register is frozen, so the pipe request is safely ignored.
  always_comb begin
    pop              = 1'b0;
    bus.rf_wr_en_o   = 1'b0;
    bus.rf_wr_adr_o  = '0;
    bus.rf_wr_data_o = '0;
    if (!rst) begin
      if ((stall_q || !pipe_req) && fifo_req) begin
        pop              = 1'b1;
        bus.rf_wr_en_o   = 1'b1;
        bus.rf_wr_adr_o  = head.rd_adr;
        bus.rf_wr_data_o = DATA_W'(head.data);
      end else if (pipe_req && !stall_q) begin
        bus.rf_wr_en_o   = 1'b1;
        bus.rf_wr_adr_o  = bus.pipe_rd_adr;
        bus.rf_wr_data_o = bus.pipe_reg_file_wr_data;
      end else if (bypass) begin
        bus.rf_wr_en_o   = 1'b1;
        bus.rf_wr_adr_o  = bus.lu_rd_adr_i;
        bus.rf_wr_data_o = bus.lu_data_i;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
    stall_d = fifo_req && !pop && (wait_q == WaitW'(MAX_WAIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4); expectations are hand-derived.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wb_port_arbiter_if #(.DATA_W(32)) bus ();

  wb_port_arbiter #(
    .DEPTH    (2),
    .MAX_WAIT (4),
    .DATA_W   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_wb_ctrl_RegWrite = we;
    bus.pipe_rd_adr           = rd;
    bus.pipe_reg_file_wr_data = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid_i  = v;
    bus.lu_rd_adr_i = rd;
    bus.lu_data_i   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] adr,
                          input logic [31:0] d);
    check({tag, ".en"}, 64'(bus.rf_wr_en_o), 64'(en));
    check({tag, ".adr"}, 64'(bus.rf_wr_adr_o), 64'(adr));
    check({tag, ".data"}, 64'(bus.rf_wr_data_o), 64'(d));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("rst_ready", 64'(bus.lu_ready_o), 64'd0);
    check("rst_wr_en", 64'(bus.rf_wr_en_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset mid-operation with two buffered results.
    set_pipe(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd5, 32'h11);
    @(negedge clk);
    check("t1_ready", 64'(bus.lu_ready_o), 64'd1);
    tick();
    set_lu(1'b1, 5'd6, 32'h22);
    @(negedge clk);
    check_wr("t1_pipe", 1'b1, 5'd3, 32'h33);
    check("t1_mask1", 64'(bus.pending_mask_o), 64'h20);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("t1_mask2", 64'(bus.pending_mask_o), 64'h60);
    check("t1_ready_rst", 64'(bus.lu_ready_o), 64'd0);
    check("t1_wr_rst", 64'(bus.rf_wr_en_o), 64'd0);
    tick();
    rst = 1'b0;
    set_pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t1_mask_clr", 64'(bus.pending_mask_o), 64'h0);
    check("t1_no_wr", 64'(bus.rf_wr_en_o), 64'd0);
    check("t1_ready_after", 64'(bus.lu_ready_o), 64'd1);
    tick();

    // x0 handling on both sources.
    set_pipe(1'b1, 5'd0, 32'hDEAD);
    set_lu(1'b1, 5'd0, 32'hBEEF);
    @(negedge clk);
    check("t5_x0_ready", 64'(bus.lu_ready_o), 64'd1);
    check("t5_x0_wr", 64'(bus.rf_wr_en_o), 64'd0);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t5_x0_mask", 64'(bus.pending_mask_o), 64'h0);
    check("t5_x0_nopush", 64'(bus.rf_wr_en_o), 64'd0);
    tick();
    set_pipe(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd9, 32'h99);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t5_mask9", 64'(bus.pending_mask_o), 64'h200);
    check_wr("t5_pop9", 1'b1, 5'd9, 32'h99);
    tick();
    @(negedge clk);
    check("t5_mask9_clr", 64'(bus.pending_mask_o), 64'h0);
    check("t5_idle", 64'(bus.rf_wr_en_o), 64'd0);
    tick();

    // Pipe priority then anti-starvation stall.
    set_pipe(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd7, 32'hAB);
    @(negedge clk);
    check_wr("t3_c0", 1'b1, 5'd3, 32'h33);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t3_stall_c%0d", c), 64'(bus.stall_o), 64'd0);
      check_wr($sformatf("t3_pipe_c%0d", c), 1'b1, 5'd3, 32'h33);
      check($sformatf("t3_mask_c%0d", c), 64'(bus.pending_mask_o), 64'h80);
      tick();
    end
    @(negedge clk);
    check("t3_stall_hi", 64'(bus.stall_o), 64'd1);
    check_wr("t3_drain", 1'b1, 5'd7, 32'hAB);
    tick();
    @(negedge clk);
    check("t3_stall_lo", 64'(bus.stall_o), 64'd0);
    check_wr("t3_held_pipe", 1'b1, 5'd3, 32'h33);
    check("t3_mask_clr", 64'(bus.pending_mask_o), 64'h0);
    tick();

    // Full / backpressure with DEPTH=2.
    set_lu(1'b1, 5'd10, 32'hA0);
    tick();
    set_lu(1'b1, 5'd11, 32'hA1);
    @(negedge clk);
    check("t4_ready1", 64'(bus.lu_ready_o), 64'd1);
    tick();
    set_lu(1'b1, 5'd12, 32'hA2);
    @(negedge clk);
    check("t4_full_ready", 64'(bus.lu_ready_o), 64'd0);
    check("t4_full_mask", 64'(bus.pending_mask_o), 64'hC00);
    check_wr("t4_busy", 1'b1, 5'd3, 32'h33);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t4_still_full", 64'(bus.lu_ready_o), 64'd0);
    check("t4_no_stall", 64'(bus.stall_o), 64'd0);
    check_wr("t4_pop10", 1'b1, 5'd10, 32'hA0);
    tick();
    @(negedge clk);
    check("t4_ready2", 64'(bus.lu_ready_o), 64'd1);
    check_wr("t4_pop11", 1'b1, 5'd11, 32'hA1);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t4_mask12", 64'(bus.pending_mask_o), 64'h1000);
    check_wr("t4_pop12", 1'b1, 5'd12, 32'hA2);
    tick();
    @(negedge clk);
    check("t4_empty_mask", 64'(bus.pending_mask_o), 64'h0);
    check("t4_idle", 64'(bus.rf_wr_en_o), 64'd0);
    tick();

    // Idle slot: bypass writes immediately, otherwise one cycle later via the FIFO.
    set_lu(1'b1, 5'd4, 32'h55);
    @(negedge clk);
    check("t6_ready", 64'(bus.lu_ready_o), 64'd1);
`ifdef WB_PORT_ARBITER_BYPASS_EN
    check_wr("t6_same", 1'b1, 5'd4, 32'h55);
`else
    check("t6_same_none", 64'(bus.rf_wr_en_o), 64'd0);
`endif
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
`ifdef WB_PORT_ARBITER_BYPASS_EN
    check("t6_next_none", 64'(bus.rf_wr_en_o), 64'd0);
    check("t6_mask", 64'(bus.pending_mask_o), 64'h0);
`else
    check_wr("t6_next", 1'b1, 5'd4, 32'h55);
    check("t6_mask", 64'(bus.pending_mask_o), 64'h10);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
